// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Two requesters each present operations on a valid/ready request channel
// (reqN_valid/reqN_ready + srca/srcb/af/i) and collect results on a
// valid/ready response channel (respN_valid/respN_ready + res/flags).
// The granted operation is registered onto alu_srca/alu_srcb/alu_af/alu_i,
// the ALU output (alu_res, {alu_ovf, alu_neg, alu_zero}) is captured after
// one EXEC cycle and held in RESP until the owner consumes it.
// busy is high whenever the block is not IDLE.
// Optional macro ALU_ARB_STAT_EN adds saturating counters stat_ops0,
// stat_ops1 (completed responses per requester) and stat_ovf (completed
// responses whose captured ovfalu flag was set).
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int AFW   = 4,
    parameter int STATW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [AFW-1:0]   req0_af,
    input  logic             req0_i,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_res,
    output logic [2:0]       resp0_flags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [AFW-1:0]   req1_af,
    input  logic             req1_i,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_res,
    output logic [2:0]       resp1_flags,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [AFW-1:0]   alu_af,
    output logic             alu_i,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ovf,
`ifdef ALU_ARB_STAT_EN
    output logic [STATW-1:0] stat_ops0,
    output logic [STATW-1:0] stat_ops1,
    output logic [STATW-1:0] stat_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               gnt;
    logic               last;
    logic [WIDTH-1:0]   op_srca, op_srcb;
    logic [AFW-1:0]     op_af;
    logic               op_i;
    logic [WIDTH-1:0]   res_q;
    logic [2:0]         flags_q;

    logic               any_valid;
    logic               cand;
    logic               accept;
    logic               resp_fire;

    // With both requesting, the one not served last wins; otherwise the
    // single requester wins. cand is only meaningful when any_valid is set.
    assign any_valid = req0_valid | req1_valid;
    assign cand      = (req0_valid & req1_valid) ? ~last : req1_valid;
    assign accept    = (state == IDLE) & any_valid;

    assign req0_ready = accept & ~cand;
    assign req1_ready = accept &  cand;

    assign resp0_valid = (state == RESP) & ~gnt;
    assign resp1_valid = (state == RESP) &  gnt;
    assign resp_fire   = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);

    assign resp0_res   = res_q;
    assign resp1_res   = res_q;
    assign resp0_flags = flags_q;
    assign resp1_flags = flags_q;

    assign alu_srca = op_srca;
    assign alu_srcb = op_srcb;
    assign alu_af   = op_af;
    assign alu_i    = op_i;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            op_srca <= '0;
            op_srcb <= '0;
            op_af   <= '0;
            op_i    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt     <= cand;
                op_srca <= cand ? req1_srca : req0_srca;
                op_srcb <= cand ? req1_srcb : req0_srcb;
                op_af   <= cand ? req1_af   : req0_af;
                op_i    <= cand ? req1_i    : req0_i;
            end
            if (state == EXEC) begin
                res_q   <= alu_res;
                flags_q <= {alu_ovf, alu_neg, alu_zero};
            end
            if (resp_fire) begin
                last <= gnt;
            end
        end
    end

`ifdef ALU_ARB_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_ovf  <= '0;
        end else if (resp_fire) begin
            if (!gnt && stat_ops0 != {STATW{1'b1}}) stat_ops0 <= stat_ops0 + STATW'(1);
            if ( gnt && stat_ops1 != {STATW{1'b1}}) stat_ops1 <= stat_ops1 + STATW'(1);
            if (flags_q[2] && stat_ovf != {STATW{1'b1}}) stat_ovf <= stat_ovf + STATW'(1);
        end
    end
`endif

endmodule
